uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
// - UART receiver: the stage downstream of the UART transmitter; consumes its serial line, returns bytes.
// - Deserialises frames on RxD (start, 8 data LSB first, [even parity], 1 stop) at a selectable baud.
// - 16x oversampling with mid-bit sampling; flags framing and parity errors.
// - Frame format and baud table match the transmitter exactly, so TxD can loop straight into RxD.
// PARAMETERS
// - CLK_FREQ    50_000_000  system clock in Hz; sets the per-baud divider values
// - OVERSAMPLE  16          sample ticks per bit; mid-bit sample is tick OVERSAMPLE/2-1 (7)
// PORTS
// - clk          in   1  system clock, all logic on rising edge
// - rst          in   1  synchronous, active-high reset
// - RxD          in   1  serial line, idle high; asynchronous to clk
// - baud_select  in   3  000=300 001=1200 010=4800 011=9600 100=19200 101=38400 110=57600 111=115200
// - Rx_EN        in   1  receiver enable; 0 holds the FSM in IDLE
// - Rx_DATA      out  8  last received byte; held until the next frame completes
// - Rx_VALID     out  1  1-cycle pulse: good frame, Rx_DATA updated
// - Rx_FERROR    out  1  1-cycle pulse: stop bit sampled 0
// - Rx_PERROR    out  1  1-cycle pulse: parity mismatch (UART_RX_PARITY_EN only)
// BEHAVIOUR
// - Reset values: Rx_DATA=8'h00, Rx_VALID=0, Rx_FERROR=0, Rx_PERROR=0.
//   Reset also sets FSM=IDLE, the synchroniser flops to 1 and all counters to 0.
// - Synchroniser: RxD passes 2 flops (rxd_s) before use; add 2 cycles to all latencies.
// - Tick generator: free counter, 1-cycle tick when count reaches DIV-1, then wraps to 0.
//   DIV = round(CLK_FREQ/(16*baud)); at 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
// - baud_select is latched on the IDLE->START transition and is fixed for the rest of the frame.
// - FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
//   - IDLE:   rxd_s==0 while Rx_EN=1 -> START; tick counter cleared at entry.
//   - START:  on tick 7, rxd_s==1 -> IDLE (false start, no output);
//             rxd_s==0 -> DATA with bit index 0.
//   - DATA:   sample every 16 ticks at mid-bit; shift in LSB first.
//             After bit 7 -> PARITY if UART_RX_PARITY_EN, else -> STOP.
//   - PARITY: sample the bit; mismatch if (^data)^bit != 0 (even parity).
//   - STOP:   at the mid-stop sample, load Rx_DATA with the shifted byte (always), then:
//             - stop=1, parity ok   -> Rx_VALID pulse -> IDLE
//             - stop=1, parity bad  -> Rx_PERROR pulse, no Rx_VALID -> IDLE
//             - stop=0              -> Rx_FERROR pulse, also Rx_PERROR if parity bad -> BREAK
//   - BREAK:  wait for rxd_s==1 -> IDLE; a held-low line produces exactly one Rx_FERROR.
// - Flag timing: all pulses assert the cycle after the mid-stop tick and last exactly 1 clk.
//   Rx_VALID and Rx_FERROR are never high together.
// - Back-to-back frames: returning to IDLE at mid-stop lets the next start edge be caught.
// - Rx_EN=0 mid-frame: abort to IDLE next cycle, no pulses, Rx_DATA unchanged.
// - rst mid-frame: all reset values apply next cycle, partial byte discarded.
// CONFIGURATION
// - UART_RX_PARITY_EN defined:
//   - 11-bit frame (start, 8 data, even parity, stop); parity checked; Rx_PERROR live.
// - UART_RX_PARITY_EN undefined:
//   - 10-bit frame (8N1); PARITY state and checker not built; Rx_PERROR tied 0.
// TESTING
// - Loop from the transmitter, baud 111, parity on: send 8'hAA -> exactly one Rx_VALID, Rx_DATA=8'hAA.
//   No Rx_FERROR or Rx_PERROR.
// - Back-to-back 8'h55, 8'hCC, 8'h89 at baud 111 -> three Rx_VALID pulses in order, no error flags.
// - Hand-driven frame 8'hCC with the parity bit inverted -> Rx_PERROR pulse, no Rx_VALID, Rx_DATA=8'hCC.
// - Stop bit driven 0, then the line held low 5 bit-times -> one Rx_FERROR, no Rx_VALID.
//   Line high again, then 8'h01 -> Rx_VALID, Rx_DATA=8'h01.
// - RxD low glitch of 3 ticks (81 clk at baud 111) -> no pulses; FSM back in IDLE before tick 8.
// - rst pulsed after data bit 3 of 8'hF0, then a clean 8'h3C -> no output for the aborted frame.
//   Then Rx_VALID with Rx_DATA=8'h3C; repeat the whole scenario at baud 011 (DIV=326).

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, control and result signals of the UART receiver
interface uart_rx_if;
    logic       RxD;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_FERROR;
    logic       Rx_PERROR;
    modport master (output RxD, baud_select, Rx_EN, input Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR);
    modport slave (input RxD, baud_select, Rx_EN, output Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver, 8 data LSB first, 1 stop; even parity when UART_RX_PARITY_EN is defined
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    function automatic int div_of(input int baud);
        return (CLK_FREQ + OVERSAMPLE * baud / 2) / (OVERSAMPLE * baud);
    endfunction
    localparam int DW = $clog2(div_of(300) + 1);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] DIV [8] = '{
        DW'(div_of(300)),   DW'(div_of(1200)),  DW'(div_of(4800)),  DW'(div_of(9600)),
        DW'(div_of(19200)), DW'(div_of(38400)), DW'(div_of(57600)), DW'(div_of(115200))
    };
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] BREAK = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY     = 3'd3;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif
    logic [2:0]    state;
    logic          rxd_m, rxd_s;
    logic [DW-1:0] cnt, div_r;
    logic [TW-1:0] tcnt;
    logic [2:0]    idx;
    logic [7:0]    shreg, data_r;
    logic          valid_r, ferr_r, bad;
    logic          tick, samp;
    assign tick = cnt == div_r - DW'(1);
    assign samp = tick && tcnt == TW'(OVERSAMPLE / 2 - 1);
    assign bus.Rx_DATA   = data_r;
    assign bus.Rx_VALID  = valid_r;
    assign bus.Rx_FERROR = ferr_r;
`ifdef UART_RX_PARITY_EN
    logic par_bad, perr_r;
    assign bad           = par_bad;
    assign bus.Rx_PERROR = perr_r;
    // parity check result of the current frame and its one-cycle error pulse
    always_ff @(posedge clk) begin
        perr_r <= 1'b0;
        if (rst)
            par_bad <= 1'b0;
        else if (bus.Rx_EN && state == PARITY && samp)
            par_bad <= (^shreg) ^ rxd_s;
        else if (bus.Rx_EN && state == STOP && samp)
            perr_r <= par_bad;
    end
`else
    assign bad           = 1'b0;
    assign bus.Rx_PERROR = 1'b0;
`endif
    // two-flop synchroniser for the asynchronous serial line, idle high
    always_ff @(posedge clk)
        {rxd_s, rxd_m} <= rst ? 2'b11 : {rxd_m, bus.RxD};
    // tick generator restarted on every frame so tick 7 lands mid-bit
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            cnt  <= '0;
            tcnt <= '0;
        end else if (tick) begin
            cnt  <= '0;
            tcnt <= tcnt == TW'(OVERSAMPLE - 1) ? '0 : tcnt + TW'(1);
        end else
            cnt <= cnt + DW'(1);
    end
    // frame FSM: samples once per bit at mid-bit and raises the result pulses
    always_ff @(posedge clk) begin
        valid_r <= 1'b0;
        ferr_r  <= 1'b0;
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            shreg  <= '0;
            data_r <= '0;
            div_r  <= '0;
        end else if (!bus.Rx_EN)
            state <= IDLE;
        else case (state)
            IDLE:
                if (!rxd_s) begin
                    state <= START;
                    div_r <= DIV[bus.baud_select];
                end
            START:
                if (samp) begin
                    state <= rxd_s ? IDLE : DATA;
                    idx   <= '0;
                end
            DATA:
                if (samp) begin
                    shreg <= {rxd_s, shreg[7:1]};
                    idx   <= idx + 3'd1;
                    state <= idx == 3'd7 ? AFTER_DATA : DATA;
                end
`ifdef UART_RX_PARITY_EN
            PARITY:
                if (samp)
                    state <= STOP;
`endif
            STOP:
                if (samp) begin
                    data_r  <= shreg;
                    valid_r <= rxd_s && !bad;
                    ferr_r  <= !rxd_s;
                    state   <= rxd_s ? IDLE : BREAK;
                end
            BREAK:
                if (rxd_s)
                    state <= IDLE;
            default:
                state <= IDLE;
        endcase
    end
endmodule
